// File: rtl/ov_bin_capture.sv
// OV sensor RGB565 byte stream to 1-bit luminance pixels for the line FIFO.
// Skips warm-up frames, gates writes on fifo_full, reports line/frame events.
module ov_bin_capture #(
  parameter int SKIP_FRAMES = 10,
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  input  logic       capture_en,
  input  logic [7:0] thresh,
  input  logic       fifo_full,
  output logic       pix_bit,
  output logic       pix_wr,
  output logic       frame_start,
  output logic       line_done,
  output logic [9:0] line_cnt,
  output logic       overflow,
  output logic       busy
);

  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int XW = $clog2(H_PIXELS + 1);

  localparam logic [1:0] S_SKIP  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_RST   =
    (SKIP_FRAMES == 0) ? S_WAIT : S_SKIP;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] skip_cnt_q, skip_cnt_d;
  logic          vsync_q, href_q;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic          s1_vld_q, s1_vld_d;
  logic [15:0]   pr_q, pr_d;
  logic [15:0]   pg_q, pg_d;
  logic [15:0]   pb_q, pb_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic          le1_q, le1_d;
  logic          pix_bit_q, pix_bit_d;
  logic          pix_wr_q, pix_wr_d;
  logic          frame_start_q, frame_start_d;
  logic          line_done_q, line_done_d;
  logic [9:0]    line_cnt_q, line_cnt_d;
  logic          overflow_q, overflow_d;

  logic          vs_rise, vs_fall, href_fall;
  logic          byte_en;
  logic [15:0]   px;
  logic [7:0]    r8, g8, b8;
  logic [15:0]   sum;
  logic [XW-1:0] x_nxt;
  logic          line_end;

  assign vs_rise   = cam_vsync & ~vsync_q;
  assign vs_fall   = ~cam_vsync & vsync_q;
  assign href_fall = ~cam_href & href_q;

  // Frame FSM; the rise after the last skipped frame arms capture
  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      S_SKIP: begin
        if (vs_rise) begin
          if (skip_cnt_q == SW'(SKIP_FRAMES)) begin
            state_d = S_WAIT;
          end else begin
            skip_cnt_d = skip_cnt_q + SW'(1);
          end
        end
      end
      S_WAIT: begin
        if (vs_fall && capture_en) begin
          state_d       = S_FRAME;
          frame_start_d = 1'b1;
        end
      end
      S_FRAME: begin
        if (vs_rise) state_d = S_WAIT;
      end
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    byte_en  = (state_q == S_FRAME) && cam_href && !cam_vsync;
    phase_d  = byte_en ? ~phase_q : 1'b0;
    hi_d     = (byte_en && !phase_q) ? cam_data : hi_q;
    s1_vld_d = byte_en && phase_q;
    px       = {hi_q, cam_data};
    r8       = {px[15:11], px[15:13]};
    g8       = {px[10:5], px[10:9]};
    b8       = {px[4:0], px[4:2]};
    pr_d     = 16'd77 * {8'd0, r8};
    pg_d     = 16'd150 * {8'd0, g8};
    pb_d     = 16'd29 * {8'd0, b8};
  end

  // Stage 2: Y >= thresh is sum >= thresh<<8
  always_comb begin
    sum         = pr_q + pg_q + pb_q;
    x_nxt       = x_cnt_q;
    pix_wr_d    = 1'b0;
    pix_bit_d   = pix_bit_q;
    overflow_d  = overflow_q;
    if (s1_vld_q && (x_cnt_q < XW'(H_PIXELS))) begin
      x_nxt = x_cnt_q + XW'(1);
      if (fifo_full) begin
        overflow_d = 1'b1;
      end else begin
        pix_wr_d  = 1'b1;
        pix_bit_d = (sum >= {thresh, 8'h00});
      end
    end
    le1_d       = href_fall && (state_q == S_FRAME);
    line_end    = le1_q && (x_nxt != '0);
    line_done_d = line_end;
    line_cnt_d  = line_cnt_q;
    if (line_end && (line_cnt_q != 10'(V_LINES))) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end
    x_cnt_d = line_end ? '0 : x_nxt;
    if (frame_start_d) begin
      line_cnt_d = '0;
      overflow_d = 1'b0;
      x_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RST;
      skip_cnt_q    <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      s1_vld_q      <= 1'b0;
      pr_q          <= '0;
      pg_q          <= '0;
      pb_q          <= '0;
      x_cnt_q       <= '0;
      le1_q         <= 1'b0;
      pix_bit_q     <= 1'b0;
      pix_wr_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;
      line_cnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      vsync_q       <= cam_vsync;
      href_q        <= cam_href;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      s1_vld_q      <= s1_vld_d;
      pr_q          <= pr_d;
      pg_q          <= pg_d;
      pb_q          <= pb_d;
      x_cnt_q       <= x_cnt_d;
      le1_q         <= le1_d;
      pix_bit_q     <= pix_bit_d;
      pix_wr_q      <= pix_wr_d;
      frame_start_q <= frame_start_d;
      line_done_q   <= line_done_d;
      line_cnt_q    <= line_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pix_bit     = pix_bit_q;
  assign pix_wr      = pix_wr_q;
  assign frame_start = frame_start_q;
  assign line_done   = line_done_q;
  assign line_cnt    = line_cnt_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q == S_FRAME);

endmodule
